// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller of the 5-stage MIPS core.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam int TNEW_W = 2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D-stage 4:1 operand mux selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b11;

  // E-stage 3:1 operand mux selects
  localparam logic [1:0] FWDE_REG = 2'b00;
  localparam logic [1:0] FWDE_M   = 2'b01;
  localparam logic [1:0] FWDE_W   = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [TNEW_W-1:0] tnew;
    logic              md_start;
    logic              md_div;
  } tag_t;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? t : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Datapath <-> hazard controller bundle: register tags in, stall and mux selects out.
interface hazard_fwd_ctrl_if;
  import hazard_pkg::*;

  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [1:0]        d_tuse_rs;
  logic [1:0]        d_tuse_rt;
  logic [REG_AW-1:0] d_dst;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic [REG_AW-1:0] e_rs;
  logic [REG_AW-1:0] e_rt;
  logic [REG_AW-1:0] m_rt;

  logic              stall;
  logic [1:0]        fwd_d_rs;
  logic [1:0]        fwd_d_rt;
  logic [1:0]        fwd_e_rs;
  logic [1:0]        fwd_e_rt;
  logic              fwd_m_rt;
  logic              md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use, e_rs, e_rt, m_rt,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use, e_rs, e_rt, m_rt,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
  );

endinterface

// File: rtl/hazard_stage_tag.sv
// One shadow-pipeline tag register: optional saturating tnew decrement, bubble insert, sync reset.
module hazard_stage_tag
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  logic dec_en,
  input  tag_t tag_in,
  output tag_t tag_q
);

  tag_t tag_d;

  always_comb begin
    tag_d = tag_in;
    if (dec_en) tag_d.tnew = sat_dec(tag_in.tnew);
    if (bubble) tag_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Stall and forwarding-select generator for the 5-stage MIPS core.
// Define HAZARD_MD_EN to add the multiply/divide busy counter and its stall term.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  hazard_fwd_ctrl_if.slave  bus
);

  tag_t d_tag, e_tag, m_tag, w_tag;
  logic stall_data;
  logic stall;
  logic md_busy;

  assign d_tag = '{dst: bus.d_dst, tnew: bus.d_tnew,
                   md_start: bus.d_md_start, md_div: bus.d_md_div};

  hazard_stage_tag u_tag_e (.clk(clk), .reset(reset), .bubble(stall), .dec_en(1'b0),
                            .tag_in(d_tag), .tag_q(e_tag));
  hazard_stage_tag u_tag_m (.clk(clk), .reset(reset), .bubble(1'b0), .dec_en(1'b1),
                            .tag_in(e_tag), .tag_q(m_tag));
  hazard_stage_tag u_tag_w (.clk(clk), .reset(reset), .bubble(1'b0), .dec_en(1'b1),
                            .tag_in(m_tag), .tag_q(w_tag));

  function automatic logic src_hazard(input logic [REG_AW-1:0] src, input logic [1:0] tuse,
                                      input tag_t e, input tag_t m);
    if (src == '0 || tuse == TUSE_NONE) return 1'b0;
    return (e.dst == src && e.tnew > tuse) || (m.dst == src && m.tnew > tuse);
  endfunction

  // A younger match whose result is not ready yet blocks older forwarding.
  function automatic logic [1:0] fwd_d_sel(input logic [REG_AW-1:0] src,
                                           input tag_t e, input tag_t m, input tag_t w);
    if (src == '0)     return FWD_RF;
    if (e.dst == src)  return (e.tnew == '0) ? FWD_E : FWD_RF;
    if (m.dst == src)  return (m.tnew == '0) ? FWD_M : FWD_RF;
    if (w.dst == src && w.tnew == '0) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [REG_AW-1:0] src,
                                           input tag_t m, input tag_t w);
    if (src == '0)     return FWDE_REG;
    if (m.dst == src)  return (m.tnew == '0) ? FWDE_M : FWDE_REG;
    if (w.dst == src && w.tnew == '0) return FWDE_W;
    return FWDE_REG;
  endfunction

  always_comb begin
    stall_data = src_hazard(bus.d_rs, bus.d_tuse_rs, e_tag, m_tag) ||
                 src_hazard(bus.d_rt, bus.d_tuse_rt, e_tag, m_tag);
  end

`ifdef HAZARD_MD_EN
  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A fresh mult/div in E reloads the counter even if a previous one is still running.
  always_comb begin
    cnt_d = cnt_q;
    if (e_tag.md_start)    cnt_d = e_tag.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign md_busy = e_tag.md_start || (cnt_q != '0);
  assign stall   = stall_data || (bus.d_md_use && md_busy);
`else
  logic unused_md_use;
  assign unused_md_use = bus.d_md_use;
  assign md_busy       = 1'b0;
  assign stall         = stall_data;
`endif

  logic unused_w_md;
  assign unused_w_md = ^{w_tag.md_start, w_tag.md_div};

  assign bus.stall    = stall;
  assign bus.md_busy  = md_busy;
  assign bus.fwd_d_rs = fwd_d_sel(bus.d_rs, e_tag, m_tag, w_tag);
  assign bus.fwd_d_rt = fwd_d_sel(bus.d_rt, e_tag, m_tag, w_tag);
  assign bus.fwd_e_rs = fwd_e_sel(bus.e_rs, m_tag, w_tag);
  assign bus.fwd_e_rt = fwd_e_sel(bus.e_rt, m_tag, w_tag);
  assign bus.fwd_m_rt = (bus.m_rt != '0) && (w_tag.dst == bus.m_rt) && (w_tag.tnew == '0);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed vector table, multi-cycle sequences, random vs model.
// Honours HAZARD_MD_EN the same way the design does.
module tb_hazard_fwd_ctrl;
  import hazard_pkg::*;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk = 1'b0;
  logic reset;
  hazard_fwd_ctrl_if hif();

  hazard_fwd_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .bus(hif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [4:0] d_rs, d_rt;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic       md_start, md_div, md_use;
    logic [4:0] e_rs, e_rt, m_rt;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic [10:0] exp;
  } vec_t;

  // Expected word layout: {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy}
  function automatic logic [10:0] ex(int s, int a, int b, int c, int d, int m, int mb);
    return {1'(s), 2'(a), 2'(b), 2'(c), 2'(d), 1'(m), 1'(mb)};
  endfunction

  function automatic stim_t mk_in(int rs, int rt, int trs, int trt, int dst, int tnew,
                                  int ers, int ert, int mrt);
    stim_t s;
    s.rst = 1'b0; s.d_rs = 5'(rs); s.d_rt = 5'(rt); s.tu_rs = 2'(trs); s.tu_rt = 2'(trt);
    s.d_dst = 5'(dst); s.d_tnew = 2'(tnew); s.md_start = 1'b0; s.md_div = 1'b0;
    s.md_use = 1'b0; s.e_rs = 5'(ers); s.e_rt = 5'(ert); s.m_rt = 5'(mrt);
    return s;
  endfunction

  function automatic logic [10:0] outs();
    return {hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt,
            hif.fwd_m_rt, hif.md_busy};
  endfunction

  task automatic apply_stimulus(input stim_t s);
    @(negedge clk);
    reset = s.rst;
    hif.d_rs = s.d_rs; hif.d_rt = s.d_rt; hif.d_tuse_rs = s.tu_rs; hif.d_tuse_rt = s.tu_rt;
    hif.d_dst = s.d_dst; hif.d_tnew = s.d_tnew; hif.d_md_start = s.md_start;
    hif.d_md_div = s.md_div; hif.d_md_use = s.md_use;
    hif.e_rs = s.e_rs; hif.e_rt = s.e_rt; hif.m_rt = s.m_rt;
    #2;
  endtask

  task automatic check_output(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = outs();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b (stall,fdrs,fdrt,fers,fert,fmrt,busy)",
               name, got, exp);
    end
  endtask

  // Reference model: instructions indexed by cycles spent since entering E (0=E, 1=M, 2=W).
  typedef struct {
    logic [4:0] dst;
    int         tnew;
    bit         md;
    bit         div;
  } minst_t;

  minst_t pipe[3];
  int     cyc;
  int     md_last;

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      pipe[k].dst = '0; pipe[k].tnew = 0; pipe[k].md = 1'b0; pipe[k].div = 1'b0;
    end
    md_last = -1;
  endfunction

  function automatic int rem(int k);
    int r;
    r = pipe[k].tnew - k;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit m_hz(logic [4:0] src, logic [1:0] tuse);
    if (src == 0 || tuse == 2'd3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].dst == src && rem(k) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] src, int start);
    if (src == 0) return 2'd0;
    for (int k = start; k <= 2; k++)
      if (pipe[k].dst == src) return (rem(k) == 0) ? 2'(k - start + 1) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [10:0] m_expect(stim_t s);
    bit st, busy;
    logic [1:0] fm;
    st = m_hz(s.d_rs, s.tu_rs) || m_hz(s.d_rt, s.tu_rt);
`ifdef HAZARD_MD_EN
    busy = pipe[0].md || (cyc <= md_last);
    st = st || (s.md_use && busy);
`else
    busy = 1'b0;
`endif
    fm = m_fwd(s.m_rt, 2);
    return {st, m_fwd(s.d_rs, 0), m_fwd(s.d_rt, 0), m_fwd(s.e_rs, 1), m_fwd(s.e_rt, 1),
            fm[0], busy};
  endfunction

  function automatic void model_step(stim_t s, bit st);
    if (s.rst) begin
      model_clear();
    end else begin
      if (pipe[0].md) md_last = cyc + (pipe[0].div ? DIV_CYCLES : MULT_CYCLES);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0].dst = st ? 5'd0 : s.d_dst;
      pipe[0].tnew = st ? 0 : int'(s.d_tnew);
      pipe[0].md = st ? 1'b0 : s.md_start;
      pipe[0].div = st ? 1'b0 : s.md_div;
    end
    cyc++;
  endfunction

  task automatic reset_dut();
    stim_t s;
    s = mk_in(0, 0, 3, 3, 0, 0, 0, 0, 0);
    s.rst = 1'b1;
    apply_stimulus(s);
    apply_stimulus(s);
    s.rst = 1'b0;
    apply_stimulus(s);
    check_output("reset_state", '0);
    model_clear();
  endtask

  task automatic md_seq(input bit is_div, input string nm);
    stim_t s;
    int cnt, exp_cnt;
    bit done;
    reset_dut();
    s = mk_in(0, 0, 3, 3, 0, 0, 0, 0, 0);
    s.md_start = 1'b1; s.md_div = is_div; s.md_use = 1'b1;
    apply_stimulus(s);
    check_output({nm, "_issue"}, '0);
    s.md_start = 1'b0;
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      apply_stimulus(s);
      if (hif.stall) cnt++;
      else done = 1'b1;
    end
`ifdef HAZARD_MD_EN
    exp_cnt = (is_div ? DIV_CYCLES : MULT_CYCLES) + 1;
`else
    exp_cnt = 0;
`endif
    n_tests++;
    if (!done || cnt != exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL %s_stall_cycles: got %0d (released=%0d) expected %0d",
               nm, cnt, done, exp_cnt);
    end
    if (done) check_output({nm, "_release"}, '0);
  endtask

  vec_t tbl[23];

  initial begin
    stim_t s;
    logic [10:0] e;

    // rs, rt, tuse_rs, tuse_rt, dst, tnew, e_rs, e_rt, m_rt
    tbl[0]  = '{mk_in(0, 0, 3, 3, 1, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mk_in(1, 0, 1, 3, 2, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{mk_in(0, 0, 3, 3, 0, 0, 1, 0, 0), ex(0, 0, 0, 1, 0, 0, 0)};
    tbl[3]  = '{mk_in(0, 0, 3, 3, 0, 0, 1, 0, 0), ex(0, 0, 0, 2, 0, 0, 0)};
    tbl[4]  = '{mk_in(2, 0, 0, 3, 0, 0, 0, 0, 0), ex(0, 3, 0, 0, 0, 0, 0)};
    tbl[5]  = '{mk_in(0, 0, 3, 3, 3, 2, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{mk_in(3, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{mk_in(3, 0, 0, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{mk_in(3, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 3, 0, 0, 0, 0, 0)};
    tbl[9]  = '{mk_in(0, 0, 3, 3, 4, 2, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{mk_in(0, 4, 1, 2, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{mk_in(0, 0, 3, 3, 0, 0, 0, 4, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{mk_in(0, 0, 3, 3, 0, 0, 0, 0, 4), ex(0, 0, 0, 0, 0, 1, 0)};
    tbl[13] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[17] = '{mk_in(0, 0, 3, 3, 5, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[18] = '{mk_in(5, 0, 0, 3, 5, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0)};
    tbl[19] = '{mk_in(5, 5, 0, 1, 0, 0, 5, 0, 0), ex(0, 1, 1, 1, 0, 0, 0)};
    tbl[20] = '{mk_in(5, 0, 0, 3, 6, 2, 5, 5, 5), ex(0, 2, 0, 1, 1, 1, 0)};
    tbl[21] = '{mk_in(6, 0, 3, 3, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[22] = '{mk_in(0, 6, 3, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0)};

    reset_dut();
    for (int i = 0; i < 23; i++) begin
      apply_stimulus(tbl[i].in);
      check_output($sformatf("tbl_row%0d", i), tbl[i].exp);
    end

    // Reset landing in the middle of a load-use stall
    reset_dut();
    apply_stimulus(mk_in(0, 0, 3, 3, 3, 2, 0, 0, 0));
    check_output("rst_mid_lw", '0);
    s = mk_in(3, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(s);
    check_output("rst_mid_stall", ex(1, 0, 0, 0, 0, 0, 0));
    s.rst = 1'b1;
    apply_stimulus(s);
    check_output("rst_mid_assert", ex(1, 0, 0, 0, 0, 0, 0));
    s.rst = 1'b0;
    apply_stimulus(s);
    check_output("rst_mid_after", '0);

    md_seq(1'b1, "div_mfhi");
    md_seq(1'b0, "mult_mflo");

`ifdef HAZARD_MD_EN
    reset_dut();
    s = mk_in(0, 0, 3, 3, 0, 0, 0, 0, 0);
    s.md_start = 1'b1; s.md_div = 1'b1;
    apply_stimulus(s);
    s.md_start = 1'b0;
    apply_stimulus(s);
    check_output("md_busy_in_e", ex(0, 0, 0, 0, 0, 0, 1));
    s.rst = 1'b1;
    apply_stimulus(s);
    check_output("md_busy_counting", ex(0, 0, 0, 0, 0, 0, 1));
    s.rst = 1'b0;
    apply_stimulus(s);
    check_output("md_busy_after_rst", '0);
`endif

    reset_dut();
    for (int i = 0; i < 2000; i++) begin
      s.rst = ($urandom_range(0, 63) == 0);
      s.d_rs = 5'($urandom_range(0, 3)); s.d_rt = 5'($urandom_range(0, 3));
      s.tu_rs = 2'($urandom_range(0, 3)); s.tu_rt = 2'($urandom_range(0, 3));
      s.d_dst = 5'($urandom_range(0, 3)); s.d_tnew = 2'($urandom_range(0, 2));
      s.md_start = ($urandom_range(0, 7) == 0); s.md_div = 1'($urandom_range(0, 1));
      s.md_use = ($urandom_range(0, 3) == 0);
      s.e_rs = 5'($urandom_range(0, 3)); s.e_rt = 5'($urandom_range(0, 3));
      s.m_rt = 5'($urandom_range(0, 3));
      apply_stimulus(s);
      e = m_expect(s);
      check_output($sformatf("rand_cyc%0d", i), e);
      model_step(s, e[10]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
